// File: rtl/halfwave_pwm.sv
// Halfwave PWM output stage: scales the sine generator's halfwave magnitudes by volume
// and drives two non-overlapping PWM outputs. Dead time on reversal: HALFWAVE_PWM_DEADTIME_EN.
module halfwave_pwm #(
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pos_in,
  input  logic [7:0] neg_in,
  input  logic [3:0] volume,
  output logic       pwm_p,
  output logic       pwm_n,
  output logic       period_tick
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned VOL_W  = 4;
  localparam int unsigned PROD_W = 12;
  localparam int unsigned DEAD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
`ifdef HALFWAVE_PWM_DEADTIME_EN
    , DEAD = 2'd3
`endif
  } state_t;

  if (DEAD_CYCLES > 15) begin : g_dead_range_check
    $error("halfwave_pwm: DEAD_CYCLES must be in 0..15");
  end

  logic [CNT_W-1:0]  cnt;
  logic              latch;
  state_t            state, state_next, tgt;
  logic [CNT_W-1:0]  duty, duty_next, sample, tgt_duty;
  logic [VOL_W:0]    vol_p1;
  logic [PROD_W-1:0] product;

  // Free-running period counter; the latch edge is the one leaving cnt == 255
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + CNT_W'(1);
  end

  assign latch = (cnt == CNT_W'(255));

  // Polarity pick: positive wins when both halves are (illegally) nonzero
  always_comb begin
    tgt    = IDLE;
    sample = '0;
    if (pos_in != '0) begin
      tgt    = POS;
      sample = pos_in;
    end else if (neg_in != '0) begin
      tgt    = NEG;
      sample = neg_in;
    end
  end

  assign vol_p1   = (VOL_W+1)'(volume) + (VOL_W+1)'(1);
  assign product  = PROD_W'(sample) * PROD_W'(vol_p1);
  assign tgt_duty = CNT_W'(product >> 4);

`ifdef HALFWAVE_PWM_DEADTIME_EN
  logic [DEAD_W-1:0] dead_cnt, dead_next;
  state_t            pend, pend_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    duty_next  = duty;
`ifdef HALFWAVE_PWM_DEADTIME_EN
    dead_next  = dead_cnt;
    pend_next  = pend;
    if (state == DEAD) begin
      if (dead_cnt <= DEAD_W'(1)) begin
        state_next = pend;
        dead_next  = '0;
      end else begin
        dead_next  = dead_cnt - DEAD_W'(1);
      end
    end else
`endif
    if (latch) begin
      duty_next  = tgt_duty;
      state_next = tgt;
`ifdef HALFWAVE_PWM_DEADTIME_EN
      // Reversal between active polarities parks in DEAD with the new target pending
      if ((DEAD_CYCLES != 0) && (state != IDLE) && (tgt != IDLE) && (tgt != state)) begin
        state_next = DEAD;
        dead_next  = DEAD_W'(DEAD_CYCLES);
        pend_next  = tgt;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty     <= '0;
`ifdef HALFWAVE_PWM_DEADTIME_EN
      dead_cnt <= '0;
      pend     <= IDLE;
`endif
    end else begin
      duty     <= duty_next;
`ifdef HALFWAVE_PWM_DEADTIME_EN
      dead_cnt <= dead_next;
      pend     <= pend_next;
`endif
    end
  end

  // Registered drives; state exclusivity keeps pwm_p and pwm_n from overlapping
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_p       <= 1'b0;
      pwm_n       <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      pwm_p       <= (state == POS) && (cnt < duty);
      pwm_n       <= (state == NEG) && (cnt < duty);
      period_tick <= (cnt == CNT_W'(254));
    end
  end

endmodule

// File: tb/tb_halfwave_pwm.sv
// Directed bench for halfwave_pwm: per-period pulse counts, first-high offsets, tick position,
// reversal dead time (when HALFWAVE_PWM_DEADTIME_EN is defined) and reset behaviour.
module tb_halfwave_pwm;

`ifdef HALFWAVE_PWM_DEADTIME_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pos_in = '0;
  logic [7:0] neg_in = '0;
  logic [3:0] volume = 4'd15;
  logic       pwm_p, pwm_n, period_tick;

  int errors = 0;
  int checks = 0;

  halfwave_pwm #(.DEAD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .pos_in(pos_in), .neg_in(neg_in), .volume(volume),
    .pwm_p(pwm_p), .pwm_n(pwm_n), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Releases reset; outputs must stay low and the first tick must land 255 clocks later
  task automatic release_and_check(input string tag);
    int bad;
    int tick_at;
    bad = 0;
    tick_at = -1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pwm_p || pwm_n) bad++;
      if (period_tick && tick_at < 0) tick_at = k;
    end
    check({tag, "_outs_low"}, bad, 0);
    check({tag, "_first_tick"}, tick_at, 255);
  endtask

  // One full period starting at the latch edge; results reflect the inputs set just before
  task automatic window(input string tag, input int exp_pc, input int exp_nc,
                        input int exp_fp, input int exp_fn);
    int pc, nc, ov, fp, fn, tk, tp;
    pc = 0; nc = 0; ov = 0; fp = -1; fn = -1; tk = 0; tp = -1;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pwm_p) begin pc++; if (fp < 0) fp = k; end
      if (pwm_n) begin nc++; if (fn < 0) fn = k; end
      if (pwm_p && pwm_n) ov++;
      if (period_tick) begin tk++; tp = k; end
    end
    check({tag, "_p_count"}, pc, exp_pc);
    check({tag, "_n_count"}, nc, exp_nc);
    check({tag, "_p_first"}, fp, exp_fp);
    check({tag, "_n_first"}, fn, exp_fn);
    check({tag, "_overlap"}, ov, 0);
    check({tag, "_tick_count"}, tk, 1);
    check({tag, "_tick_pos"}, tp, 255);
  endtask

  initial begin
    pos_in = 8'd128;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_pwm_p", int'(pwm_p), 0);
    check("rst_pwm_n", int'(pwm_n), 0);
    check("rst_tick", int'(period_tick), 0);
    release_and_check("startup");

    window("pos128", 128, 0, 1, -1);

    pos_in = 8'd0; neg_in = 8'd0;
    window("idle", 0, 0, -1, -1);

    neg_in = 8'd255;
    window("neg255", 0, 255, -1, 1);

    volume = 4'd0;
    window("neg255_vol0", 0, 15, -1, 1);

    volume = 4'd15; neg_in = 8'd0; pos_in = 8'd200;
    window("rev_to_pos", 200 - D, 0, 1 + D, -1);

    pos_in = 8'd0; neg_in = 8'd200;
    window("rev_to_neg", 0, 200 - D, -1, 1 + D);

    pos_in = 8'd50; neg_in = 8'd60;
    window("both_rev", 50 - D, 0, 1 + D, -1);
    window("both_stay", 50, 0, 1, -1);

    neg_in = 8'd0; pos_in = 8'd255;
    window("pos255", 255, 0, 1, -1);

    volume = 4'd7;
    window("pos255_vol7", 127, 0, 1, -1);

    pos_in = 8'd100; volume = 4'd3;
    window("pos100_vol3", 25, 0, 1, -1);

    // Reverse polarity, then reset two clocks into the period (inside DEAD when enabled)
    pos_in = 8'd0; neg_in = 8'd100; volume = 4'd15;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("dead_rst_pwm_p", int'(pwm_p), 0);
    check("dead_rst_pwm_n", int'(pwm_n), 0);
    check("dead_rst_tick", int'(period_tick), 0);
    release_and_check("after_dead_rst");

    window("neg100", 0, 100, -1, 1);

    // Reset in the middle of an active positive period
    neg_in = 8'd0; pos_in = 8'd255;
    repeat (100) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_pwm_p", int'(pwm_p), 0);
    check("mid_rst_pwm_n", int'(pwm_n), 0);
    check("mid_rst_tick", int'(period_tick), 0);
    release_and_check("after_mid_rst");

    window("pos255_again", 255, 0, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
